// File: rtl/lcd_write_ctrl.sv
// Write-only HD44780 character-LCD controller: runs the power-on init sequence,
// then turns {RS, byte} requests into setup / EN pulse / hold / command-wait pin timing.
module lcd_write_ctrl #(
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned EN_HIGH_CYC   = 12,
  parameter int unsigned HOLD_CYC      = 2,
  parameter int unsigned CMD_WAIT_CYC  = 2000,
  parameter int unsigned LONG_WAIT_CYC = 82000,
  parameter int unsigned PWR_WAIT_CYC  = 750000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_vld,
  input  logic       i_req_rs,
  input  logic [7:0] i_req_data,
  output logic       o_req_rdy,
  output logic       o_init_done,
  output logic       o_lcd_on,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic [7:0] o_lcd_data
);

  localparam int unsigned MAX_A   = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
  localparam int unsigned MAX_B   = (HOLD_CYC > CMD_WAIT_CYC) ? HOLD_CYC : CMD_WAIT_CYC;
  localparam int unsigned MAX_C   = (LONG_WAIT_CYC > PWR_WAIT_CYC) ? LONG_WAIT_CYC : PWR_WAIT_CYC;
  localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_LOAD,
    SETUP,
    EN_HI,
    HOLD,
    WAIT,
    IDLE
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [1:0]        idx, idx_n;
  logic              rs_q, rs_n;
  logic [7:0]        data_q, data_n;
  logic              done_q, done_n;
  logic              rdy_q, en_q, on_q;
  logic [7:0]        init_byte;
  logic              long_wait;
  logic              cnt_last;

  always_comb begin
    init_byte = 8'h38;
    case (idx)
      2'd0: init_byte = 8'h38;
      2'd1: init_byte = 8'h0C;
      2'd2: init_byte = 8'h01;
      2'd3: init_byte = 8'h06;
      default: init_byte = 8'h38;
    endcase
  end

  // Clear and return-home instructions need the long post-pulse wait.
  assign long_wait = !rs_q && (data_q[7:2] == '0) && (data_q[1:0] != '0);
  assign cnt_last  = (cnt == CNT_W'(1));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    rs_n    = rs_q;
    data_n  = data_q;
    done_n  = done_q;
    case (state)
      PWR_WAIT: begin
        if (cnt_last) state_n = INIT_LOAD;
        else          cnt_n   = cnt - CNT_W'(1);
      end
      INIT_LOAD: begin
        rs_n    = 1'b0;
        data_n  = init_byte;
        state_n = SETUP;
        cnt_n   = CNT_W'(SETUP_CYC);
      end
      SETUP: begin
        if (cnt_last) begin
          state_n = EN_HI;
          cnt_n   = CNT_W'(EN_HIGH_CYC);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      EN_HI: begin
        if (cnt_last) begin
          state_n = HOLD;
          cnt_n   = CNT_W'(HOLD_CYC);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_last) begin
          state_n = WAIT;
          cnt_n   = long_wait ? CNT_W'(LONG_WAIT_CYC) : CNT_W'(CMD_WAIT_CYC);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      WAIT: begin
        if (!cnt_last) begin
          cnt_n = cnt - CNT_W'(1);
        end else if (done_q) begin
          state_n = IDLE;
        end else if (idx == 2'd3) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          idx_n   = idx + 2'd1;
          state_n = INIT_LOAD;
        end
      end
      IDLE: begin
        if (i_req_vld) begin
          rs_n    = i_req_rs;
          data_n  = i_req_data;
          state_n = SETUP;
          cnt_n   = CNT_W'(SETUP_CYC);
        end
      end
      default: state_n = PWR_WAIT;
    endcase
  end

  // Pin-facing flags are registered from the next state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= PWR_WAIT;
      cnt    <= CNT_W'(PWR_WAIT_CYC);
      idx    <= '0;
      rs_q   <= 1'b0;
      data_q <= '0;
      done_q <= 1'b0;
      rdy_q  <= 1'b0;
      en_q   <= 1'b0;
      on_q   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      rs_q   <= rs_n;
      data_q <= data_n;
      done_q <= done_n;
      rdy_q  <= (state_n == IDLE);
      en_q   <= (state_n == EN_HI);
      on_q   <= 1'b1;
    end
  end

  assign o_req_rdy   = rdy_q;
  assign o_init_done = done_q;
  assign o_lcd_on    = on_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_en    = en_q;
  assign o_lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Scoreboard bench for lcd_write_ctrl: stimulus queues expected EN pulses and
// ready-return cycles, a negedge monitor pops and compares as the pins move.
module tb_lcd_write_ctrl;

  localparam int unsigned P_SETUP = 1;
  localparam int unsigned P_EN    = 2;
  localparam int unsigned P_HOLD  = 1;
  localparam int unsigned P_CMD   = 4;
  localparam int unsigned P_LONG  = 10;
  localparam int unsigned P_PWR   = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_vld;
  logic       req_rs;
  logic [7:0] req_data;
  logic       req_rdy;
  logic       init_done;
  logic       lcd_on;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  lcd_write_ctrl #(
    .SETUP_CYC     (P_SETUP),
    .EN_HIGH_CYC   (P_EN),
    .HOLD_CYC      (P_HOLD),
    .CMD_WAIT_CYC  (P_CMD),
    .LONG_WAIT_CYC (P_LONG),
    .PWR_WAIT_CYC  (P_PWR)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_vld   (req_vld),
    .i_req_rs    (req_rs),
    .i_req_data  (req_data),
    .o_req_rdy   (req_rdy),
    .o_init_done (init_done),
    .o_lcd_on    (lcd_on),
    .o_lcd_rs    (lcd_rs),
    .o_lcd_rw    (lcd_rw),
    .o_lcd_en    (lcd_en),
    .o_lcd_data  (lcd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;
    logic       done;
  } pulse_t;

  pulse_t exp_pulse_q[$];
  int     exp_rdy_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor
  logic       pen = 1'b0, prdy = 1'b0, trk = 1'b0;
  logic       r_rs, r_stable, r_done;
  logic [7:0] r_data;
  int         r_rise, r_len;

  always @(negedge clk) begin
    if (rst) begin
      trk  = 1'b0;
      pen  = 1'b0;
      prdy = 1'b0;
    end else begin
      if (lcd_en && !pen) begin
        trk      = 1'b1;
        r_rs     = lcd_rs;
        r_data   = lcd_data;
        r_rise   = cyc;
        r_len    = 1;
        r_stable = 1'b1;
        r_done   = init_done;
      end else if (lcd_en && trk) begin
        r_len++;
        if (lcd_rs != r_rs || lcd_data != r_data) r_stable = 1'b0;
      end else if (!lcd_en && pen && trk) begin
        if (lcd_rs != r_rs || lcd_data != r_data) r_stable = 1'b0;
        trk = 1'b0;
        if (exp_pulse_q.size() == 0) begin
          check("unexpected_pulse", int'(r_data), -1);
        end else begin
          pulse_t e;
          e = exp_pulse_q.pop_front();
          check("pulse_rs",     int'(r_rs),     int'(e.rs));
          check("pulse_data",   int'(r_data),   int'(e.data));
          check("pulse_rise",   r_rise,         e.rise);
          check("pulse_len",    r_len,          int'(P_EN));
          check("pulse_stable", int'(r_stable), 1);
          check("pulse_done",   int'(r_done),   int'(e.done));
          check("pulse_rw",     int'(lcd_rw),   0);
        end
      end
      if (req_rdy && !prdy) begin
        if (exp_rdy_q.size() == 0) begin
          check("unexpected_rdy", cyc, -1);
        end else begin
          check("rdy_cycle", cyc, exp_rdy_q.pop_front());
          check("rdy_done",  int'(init_done), 1);
        end
      end
      pen  = lcd_en;
      prdy = req_rdy;
    end
  end

  // Expected init pulses relative to R, the first posedge with reset low.
  task automatic push_init(input int r);
    int         rise_off[4] = '{21, 30, 39, 54};
    logic [7:0] bytes[4]    = '{8'h38, 8'h0C, 8'h01, 8'h06};
    for (int i = 0; i < 4; i++)
      exp_pulse_q.push_back('{rs: 1'b0, data: bytes[i], rise: r + rise_off[i], done: 1'b0});
    exp_rdy_q.push_back(r + 61);
  endtask

  // Leaves vld high; returns at the negedge following the accept edge.
  task automatic issue(input logic rs, input logic [7:0] data, input int rdy_off);
    int a;
    int k;
    req_vld  = 1'b1;
    req_rs   = rs;
    req_data = data;
    k = 0;
    while (!req_rdy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!req_rdy) begin
      check("accept_timeout", 0, 1);
      return;
    end
    a = cyc + 1;
    exp_pulse_q.push_back('{rs: rs, data: data, rise: a + 1, done: 1'b1});
    exp_rdy_q.push_back(a + rdy_off);
    @(negedge clk);
  endtask

  task automatic wait_rdy();
    int k = 0;
    while (!req_rdy && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!req_rdy) check("rdy_timeout", 0, 1);
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rdy_off;
  } vec_t;

  vec_t vecs[8] = '{
    '{1'b1, 8'h41, 8},
    '{1'b0, 8'h01, 14},
    '{1'b0, 8'h80, 8},
    '{1'b0, 8'h03, 14},
    '{1'b0, 8'h02, 14},
    '{1'b0, 8'h04, 8},
    '{1'b0, 8'h00, 8},
    '{1'b1, 8'h02, 8}
  };

  initial begin
    int r;
    int k;
    rst      = 1'b1;
    req_vld  = 1'b0;
    req_rs   = 1'b0;
    req_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rdy",  int'(req_rdy),   0);
    check("rst_done", int'(init_done), 0);
    check("rst_on",   int'(lcd_on),    0);
    check("rst_rs",   int'(lcd_rs),    0);
    check("rst_rw",   int'(lcd_rw),    0);
    check("rst_en",   int'(lcd_en),    0);
    check("rst_data", int'(lcd_data),  0);

    rst = 1'b0;
    r = cyc + 1;
    push_init(r);
    @(negedge clk);
    check("on_after_release", int'(lcd_on), 1);
    check("en_pwr_wait",      int'(lcd_en), 0);
    wait_rdy();

    foreach (vecs[i]) begin
      issue(vecs[i].rs, vecs[i].data, vecs[i].rdy_off);
      req_vld  = 1'b0;
      req_data = 8'hFF;
      req_rs   = ~vecs[i].rs;
      wait_rdy();
    end

    // Two queued bytes with vld held high; the payload switches while busy.
    issue(1'b1, 8'h48, 8);
    issue(1'b1, 8'h49, 8);
    req_vld  = 1'b0;
    req_data = 8'hAA;
    wait_rdy();

    // Reset in the middle of an EN pulse.
    issue(1'b1, 8'h55, 8);
    req_vld = 1'b0;
    k = 0;
    while (!lcd_en && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("en_seen_before_reset", int'(lcd_en), 1);
    rst = 1'b1;
    exp_pulse_q.delete();
    exp_rdy_q.delete();
    @(negedge clk);
    check("mid_rst_en",   int'(lcd_en),    0);
    check("mid_rst_done", int'(init_done), 0);
    check("mid_rst_rdy",  int'(req_rdy),   0);
    check("mid_rst_data", int'(lcd_data),  0);
    check("mid_rst_on",   int'(lcd_on),    0);
    @(negedge clk);
    rst = 1'b0;
    r = cyc + 1;
    push_init(r);
    // Request raised during init must be held off and then taken once.
    issue(1'b1, 8'h5A, 8);
    req_vld = 1'b0;
    wait_rdy();

    k = 0;
    while ((exp_pulse_q.size() != 0 || exp_rdy_q.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    check("pulse_q_empty", exp_pulse_q.size(), 0);
    check("rdy_q_empty",   exp_rdy_q.size(),   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
